// File: rtl/pipeline_sequencer_if.sv
// ============================================================================
//  Module   : pipeline_sequencer_if
//  Purpose  : Bundles the command inputs (debug run/step, hazard detector
//             requests, HALT decode) and the pipeline control outputs of
//             pipeline_sequencer.
//  Modports : master - command side (debug unit / hazard unit / decode).
//                      Drives the commands and observes the controls.
//             slave  - the sequencer. Samples the commands and drives the
//                      controls.
//  Signals  : start, mode, step, load_stall, branch_flush, halt_instr (cmd)
//             pipe_en, pc_we, if_id_we, if_id_flush, id_ex_bubble,
//             running, done, cycle_count[CNT_BITS-1:0]                  (ctl)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_sequencer_if #(
  parameter int CNT_BITS = 32
);
  logic                start;
  logic                mode;
  logic                step;
  logic                load_stall;
  logic                branch_flush;
  logic                halt_instr;
  logic                pipe_en;
  logic                pc_we;
  logic                if_id_we;
  logic                if_id_flush;
  logic                id_ex_bubble;
  logic                running;
  logic                done;
  logic [CNT_BITS-1:0] cycle_count;

  modport master (
    output start, mode, step, load_stall, branch_flush, halt_instr,
    input  pipe_en, pc_we, if_id_we, if_id_flush, id_ex_bubble,
           running, done, cycle_count
  );

  modport slave (
    input  start, mode, step, load_stall, branch_flush, halt_instr,
    output pipe_en, pc_we, if_id_we, if_id_flush, id_ex_bubble,
           running, done, cycle_count
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_sequencer.sv
// ============================================================================
//  Module   : pipeline_sequencer
//  Purpose  : Run/stall/flush controller for a 5-stage pipeline. It merges
//             the hazard detector's stall and flush requests with the debug
//             unit's run/step commands. A HALT seen in ID drains the pipeline
//             for DRAIN_CYCLES advance cycles before the sequencer reports
//             completion.
//  Ports    : clk  - clock, rising edge
//             rst  - synchronous reset, active-high
//             sq   - pipeline_sequencer_if.slave (commands in, controls out)
//  Params   : CNT_BITS     - width of the advance-cycle counter
//             DRAIN_CYCLES - advance cycles after HALT leaves ID (>=1)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_sequencer #(
  parameter int CNT_BITS     = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  pipeline_sequencer_if.slave   sq
);

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          state;
  logic                mode_q;
  logic [DW-1:0]       drain_cnt;
  logic [CNT_BITS-1:0] cycle_count;
  logic                adv;
  logic                halt_take;

  // An advance is a cycle in which the pipeline latches move. In step mode
  // that only happens on an i_step pulse, including while draining.
  always_comb begin
    adv = (state == S_RUN) ||
          ((state == S_STEP) && sq.step) ||
          ((state == S_DRAIN) && (mode_q ? sq.step : 1'b1));
  end

  // HALT only takes effect when neither hazard request overrides it.
  always_comb begin
    halt_take = adv && ((state == S_RUN) || (state == S_STEP)) &&
                !sq.branch_flush && !sq.load_stall && sq.halt_instr;
  end

  always_comb begin
    sq.pc_we        = 1'b0;
    sq.if_id_we     = 1'b0;
    sq.if_id_flush  = 1'b0;
    sq.id_ex_bubble = 1'b0;
    if (adv) begin
      if (state == S_DRAIN) begin
        // Keep fetch frozen and push NOPs behind the HALT.
        sq.if_id_we    = 1'b1;
        sq.if_id_flush = 1'b1;
      end else if (sq.branch_flush) begin
        // A taken branch squashes the load-use stall raised alongside it.
        sq.pc_we       = 1'b1;
        sq.if_id_we    = 1'b1;
        sq.if_id_flush = 1'b1;
      end else if (sq.load_stall) begin
        sq.id_ex_bubble = 1'b1;
      end else if (sq.halt_instr) begin
        sq.if_id_we    = 1'b1;
        sq.if_id_flush = 1'b1;
      end else begin
        sq.pc_we    = 1'b1;
        sq.if_id_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      drain_cnt   <= '0;
      cycle_count <= '0;
    end else begin
      if (adv && (cycle_count != {CNT_BITS{1'b1}})) begin
        cycle_count <= cycle_count + CNT_BITS'(1);
      end
      case (state)
        S_IDLE: begin
          if (sq.start) begin
            mode_q      <= sq.mode;
            cycle_count <= '0;
            state       <= sq.mode ? S_STEP : S_RUN;
          end
        end
        S_RUN, S_STEP: begin
          if (halt_take) begin
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (adv) begin
            drain_cnt <= drain_cnt + DW'(1);
            if (drain_cnt == DRAIN_LAST) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign sq.pipe_en     = adv;
  assign sq.running     = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
  assign sq.done        = (state == S_DONE);
  assign sq.cycle_count = cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
// ============================================================================
//  Module   : tb_pipeline_sequencer
//  Purpose  : Self-checking bench for pipeline_sequencer. A phase-level
//             reference model predicts every control output each cycle;
//             literal expectations pin key scenario results.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_sequencer;

  localparam int CB     = 5;
  localparam int DRAIN  = 4;
  localparam int CNTMAX = (1 << CB) - 1;

  localparam int PH_IDLE   = 0;
  localparam int PH_ACTIVE = 1;
  localparam int PH_DRAIN  = 2;
  localparam int PH_DONE   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_BITS(CB)) bus ();

  pipeline_sequencer #(.CNT_BITS(CB), .DRAIN_CYCLES(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: where the pipeline is in its life, and how many
  // advance cycles of draining are still owed.
  int ph         = PH_IDLE;
  bit step_mode  = 1'b0;
  int drain_left = 0;
  int cnt        = 0;

  // Outputs captured at the most recent sample point.
  logic cap_pe, cap_pc, cap_ifwe, cap_fl, cap_bub;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic m, input logic st,
                      input logic ls, input logic bf, input logic hi);
    bit moving, e_pc, e_we, e_fl, e_bub;
    rst              = r;
    bus.start        = s;
    bus.mode         = m;
    bus.step         = st;
    bus.load_stall   = ls;
    bus.branch_flush = bf;
    bus.halt_instr   = hi;
    @(negedge clk);
    // The pipeline moves when it is working (or draining) and either free
    // running or given a step pulse.
    moving = ((ph == PH_ACTIVE) || (ph == PH_DRAIN)) && (!step_mode || st);
    {e_pc, e_we, e_fl, e_bub} = 4'b0000;
    if (moving) begin
      if (ph == PH_DRAIN) {e_pc, e_we, e_fl, e_bub} = 4'b0110;
      else if (bf)        {e_pc, e_we, e_fl, e_bub} = 4'b1110;
      else if (ls)        {e_pc, e_we, e_fl, e_bub} = 4'b0001;
      else if (hi)        {e_pc, e_we, e_fl, e_bub} = 4'b0110;
      else                {e_pc, e_we, e_fl, e_bub} = 4'b1100;
    end
    chk("pipe_en",      32'(bus.pipe_en),      32'(moving));
    chk("pc_we",        32'(bus.pc_we),        32'(e_pc));
    chk("if_id_we",     32'(bus.if_id_we),     32'(e_we));
    chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_fl));
    chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_bub));
    chk("running",      32'(bus.running),      32'((ph == PH_ACTIVE) || (ph == PH_DRAIN)));
    chk("done",         32'(bus.done),         32'(ph == PH_DONE));
    chk("cycle_count",  32'(bus.cycle_count),  32'(cnt));
    cap_pe = bus.pipe_en; cap_pc = bus.pc_we; cap_ifwe = bus.if_id_we;
    cap_fl = bus.if_id_flush; cap_bub = bus.id_ex_bubble;
    @(posedge clk);
    if (r) begin
      ph = PH_IDLE; step_mode = 1'b0; drain_left = 0; cnt = 0;
    end else begin
      if (moving && cnt < CNTMAX) cnt++;
      case (ph)
        PH_IDLE: if (s) begin ph = PH_ACTIVE; step_mode = m; cnt = 0; end
        PH_ACTIVE: if (moving && !bf && !ls && hi) begin
          ph = PH_DRAIN; drain_left = DRAIN;
        end
        PH_DRAIN: if (moving) begin
          drain_left--;
          if (drain_left == 0) ph = PH_DONE;
        end
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic idle_tick();  tick(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step_tick();  tick(0, 0, 0, 1, 0, 0, 0); endtask
  task automatic reset_tick(); tick(1, 0, 0, 0, 0, 0, 0); endtask

  initial begin
    bus.start = 0; bus.mode = 0; bus.step = 0;
    bus.load_stall = 0; bus.branch_flush = 0; bus.halt_instr = 0;
    // Bring the DUT out of its unknown power-up state before comparing.
    @(posedge clk); #1;
    reset_tick();
    chk("reset_count_lit", 32'(bus.cycle_count), 32'd0);
    chk("reset_done_lit",  32'(bus.done),        32'd0);

    // T1: continuous run, ten clean cycles
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) idle_tick();
    chk("t1_count_lit",   32'(bus.cycle_count), 32'd10);
    chk("t1_running_lit", 32'(bus.running),     32'd1);

    // T2: single load-use stall
    tick(0, 0, 0, 0, 1, 0, 0);
    chk("t2_stall_lit", {27'd0, cap_pe, cap_pc, cap_ifwe, cap_fl, cap_bub}, 32'b10001);
    idle_tick();
    chk("t2_after_lit", {27'd0, cap_pe, cap_pc, cap_ifwe, cap_fl, cap_bub}, 32'b11100);

    // T3: flush wins over simultaneous stall; start outside IDLE ignored
    tick(0, 0, 0, 0, 1, 1, 0);
    chk("t3_flush_lit", {27'd0, cap_pe, cap_pc, cap_ifwe, cap_fl, cap_bub}, 32'b11110);
    tick(0, 1, 1, 0, 0, 0, 1);   // halt held off by nothing -> drains
    reset_tick();

    // T4: halt at cycle 5, four drain cycles with noisy hazard inputs, DONE
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) idle_tick();
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
    idle_tick();
    chk("t4_count_lit", 32'(bus.cycle_count), 32'd9);
    chk("t4_done_lit",  32'(bus.done),        32'd1);
    tick(0, 1, 0, 1, 0, 0, 0);
    tick(0, 1, 1, 1, 0, 0, 0);
    chk("t4_frozen_lit", 32'(bus.cycle_count), 32'd9);
    chk("t4_still_done_lit", 32'(bus.done), 32'd1);
    reset_tick();

    // T5: step mode; a step together with start is not an advance
    tick(0, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle_tick();
    chk("t5_nostep_lit", 32'(bus.cycle_count), 32'd0);
    for (int i = 0; i < 3; i++) begin step_tick(); idle_tick(); end
    chk("t5_step3_lit", 32'(bus.cycle_count), 32'd3);
    tick(0, 0, 0, 0, 0, 0, 1);   // halt without step: frozen
    tick(0, 0, 0, 1, 0, 0, 1);   // halt on a step -> drain
    for (int i = 0; i < 4; i++) begin idle_tick(); idle_tick(); step_tick(); end
    idle_tick();
    chk("t5_done_lit",  32'(bus.done),        32'd1);
    chk("t5_count_lit", 32'(bus.cycle_count), 32'd8);
    reset_tick();

    // T6: reset in the middle of draining
    tick(0, 1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    idle_tick();
    idle_tick();
    reset_tick();
    chk("t6_count_lit",   32'(bus.cycle_count), 32'd0);
    chk("t6_running_lit", 32'(bus.running),     32'd0);
    idle_tick();

    // Counter saturation
    tick(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNTMAX + 4; i++) idle_tick();
    chk("sat_count_lit", 32'(bus.cycle_count), 32'(CNTMAX));
    reset_tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
